// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and default parameter values for the UART blocks
package uart_pkg;
  localparam int DEF_MAX_DATA_BITS = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_BAUD_PERIOD_BITS = 16;
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: valid/ready write port carrying words into the transmitter
interface uart_tx_cfg_if import uart_pkg::*; #(
  parameter int MAX_DATA_BITS = DEF_MAX_DATA_BITS
);
  logic tx_valid;
  logic [MAX_DATA_BITS-1:0] tx_data;
  logic tx_ready;
  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two circular FIFO with synchronous clear, shared by tx and rx
module uart_tx_fifo import uart_pkg::*; #(
  parameter int WIDTH = DEF_MAX_DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-buffered UART transmitter with per-frame latched format
module uart_tx_cfg import uart_pkg::*; #(
  parameter int MAX_DATA_BITS = DEF_MAX_DATA_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int BAUD_PERIOD_BITS = DEF_BAUD_PERIOD_BITS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            sync_reset,
  uart_tx_cfg_if.slave                    tx,
  input  logic [BAUD_PERIOD_BITS-1:0]     baud_rate_period_m1,
  input  logic [3:0]                      cfg_data_bits,
  input  logic [1:0]                      cfg_parity,
  input  logic                            cfg_stop2,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            tx_active,
  output logic                            TXD
);
  tx_state_t state, state_d;
  logic [BAUD_PERIOD_BITS-1:0] baud_cnt, baud_d;
  logic [3:0] bit_cnt, bit_d, nbits, nb_eff;
  logic [MAX_DATA_BITS-1:0] shreg, fifo_dout, din_m;
  logic par_en, par_bit, stop2, pop, full, empty, bit_end;
  uart_tx_fifo #(.WIDTH(MAX_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .reset_n, .clr(sync_reset), .push(tx.tx_valid && tx.tx_ready), .pop,
    .din(tx.tx_data), .dout(fifo_dout), .full, .empty, .count(fifo_count)
  );
  assign tx.tx_ready = !full;
  assign tx_active = state != IDLE;
  assign bit_end = baud_cnt == baud_rate_period_m1;
  assign nb_eff = (cfg_data_bits < 4'd5 || cfg_data_bits > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) : cfg_data_bits;
  // Unsent high bits are cleared so they neither reach the line nor the parity
  assign din_m = fifo_dout & ~({MAX_DATA_BITS{1'b1}} << nb_eff);
  assign TXD = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par_bit : 1'b1;
  always_comb begin
    state_d = state;
    baud_d = (state == IDLE || bit_end) ? '0 : baud_cnt + BAUD_PERIOD_BITS'(1);
    bit_d = bit_cnt;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_d = START;
        pop = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (bit_end) begin
        state_d = bit_cnt == nbits - 4'd1 ? (par_en ? PARITY : STOP) : DATA;
        bit_d = bit_cnt == nbits - 4'd1 ? '0 : bit_cnt + 4'd1;
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        bit_d = '0;
      end
      STOP: if (bit_end) begin
        state_d = bit_cnt == {3'b0, stop2} ? (empty ? IDLE : START) : STOP;
        pop = bit_cnt == {3'b0, stop2} && !empty;
        bit_d = bit_cnt + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      nbits <= 4'(MAX_DATA_BITS);
      par_en <= 1'b0;
      par_bit <= 1'b0;
      stop2 <= 1'b0;
    end else if (sync_reset) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_d;
      baud_cnt <= baud_d;
      bit_cnt <= bit_d;
      if (pop) begin
        shreg <= din_m;
        nbits <= nb_eff;
        par_en <= cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD;
        par_bit <= ^din_m ^ (cfg_parity == PAR_ODD);
        stop2 <= cfg_stop2;
      end else if (state == DATA && bit_end) shreg <= shreg >> 1;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: table vectors, corner sequences and random bursts against a frame-level model
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_reset = 1'b0;
  logic [15:0] baud_rate_period_m1 = 16'd3;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'd0;
  logic cfg_stop2 = 1'b0;
  logic [2:0] fifo_count;
  logic tx_active, TXD;
  uart_tx_cfg_if #(.MAX_DATA_BITS(8)) bus ();
  uart_tx_cfg #(.MAX_DATA_BITS(8), .FIFO_DEPTH(4), .BAUD_PERIOD_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .tx(bus),
    .baud_rate_period_m1(baud_rate_period_m1), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .fifo_count(fifo_count),
    .tx_active(tx_active), .TXD(TXD)
  );
  always #5 clk = ~clk;

  typedef struct {
    int pm1;
    int nb;
    int par;
    bit s2;
    logic [7:0] data;
    logic [15:0] bits;
    int len;
  } vec_t;
  vec_t vecs[8];
  int n_chk = 0, n_fail = 0;
  bit cap[$];
  bit exp_q[$];
  int runs = 0, cap_base = 0, run_base = 0;
  logic prev_act = 1'b0;

  // Line recorder: every clock while a frame is active, plus count of active bursts
  always @(negedge clk) begin
    if (tx_active === 1'b1) cap.push_back(TXD);
    if (tx_active === 1'b1 && prev_act !== 1'b1) runs++;
    prev_act = tx_active;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_cap();
    cap_base = cap.size();
    run_base = runs;
    exp_q.delete();
  endtask

  task automatic add_frame(input logic [7:0] d, input int nb, input int par, input bit s2, input int p);
    bit b[$];
    int n, ones;
    n = (nb < 5 || nb > 8) ? 8 : nb;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par == 1 || par == 2) b.push_back(((ones % 2) == 1) ^ (par == 2));
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    foreach (b[j]) repeat (p) exp_q.push_back(b[j]);
  endtask

  task automatic add_pattern(input logic [15:0] bits, input int len, input int p);
    for (int i = 0; i < len; i++) repeat (p) exp_q.push_back(bits[i]);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && tx_active !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5000 && tx_active === 1'b1; i++) @(negedge clk);
    check("done_timeout", tx_active, 0);
  endtask

  task automatic compare_wave(input string name);
    int mism, n;
    mism = 0;
    n = cap.size() - cap_base;
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (cap[cap_base + i] !== exp_q[i]) mism++;
    check({name, "_len"}, n, exp_q.size());
    check({name, "_bits"}, mism, 0);
    check({name, "_runs"}, runs - run_base, 1);
  endtask

  task automatic set_cfg(input int pm1, input int nb, input int par, input bit s2);
    baud_rate_period_m1 = 16'(pm1);
    cfg_data_bits = 4'(nb);
    cfg_parity = 2'(par);
    cfg_stop2 = s2;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    set_cfg(v.pm1, v.nb, v.par, v.s2);
    start_cap();
    bus.tx_valid = 1'b1;
    bus.tx_data = v.data;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("lat_n1_txd", TXD, 1);
    check("lat_n1_active", tx_active, 0);
    @(negedge clk);
    check("lat_n2_txd", TXD, 0);
    wait_done();
    add_pattern(v.bits, v.len, v.pm1 + 1);
    compare_wave("vec");
  endtask

  initial begin
    vecs[0] = '{3, 8, 0, 1'b0, 8'hA5, 16'h034A, 10};
    vecs[1] = '{3, 7, 1, 1'b1, 8'h41, 16'h0682, 11};
    vecs[2] = '{3, 7, 2, 1'b1, 8'h41, 16'h0782, 11};
    vecs[3] = '{3, 5, 0, 1'b0, 8'hFF, 16'h007E, 7};
    vecs[4] = '{2, 6, 2, 1'b0, 8'h2C, 16'h0158, 9};
    vecs[5] = '{1, 3, 3, 1'b0, 8'h0F, 16'h021E, 10};
    vecs[6] = '{2, 8, 1, 1'b0, 8'h80, 16'h0700, 11};
    vecs[7] = '{1, 12, 0, 1'b1, 8'h3C, 16'h0678, 11};
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", TXD, 1);
    check("rst_active", tx_active, 0);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_count", fifo_count, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hold tx_valid from cycle 0: five words fit (one leaves for the line), then full
    @(negedge clk);
    set_cfg(3, 8, 0, 1'b0);
    start_cap();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ready_c%0d", k), bus.tx_ready, k < 5);
      if (k == 5) check("full_count", fifo_count, 4);
      bus.tx_valid = 1'b1;
      bus.tx_data = 8'(k);
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    check("full_count_hold", fifo_count, 4);
    for (int k = 0; k < 5; k++) add_frame(8'(k), 8, 0, 1'b0, 4);
    wait_done();
    compare_wave("drain");

    // Flush mid data bit with three words queued; a coincident push is dropped
    @(negedge clk);
    start_cap();
    for (int k = 1; k <= 4; k++) begin
      bus.tx_valid = 1'b1;
      bus.tx_data = 8'(k * 17);
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_pre_count", fifo_count, 3);
    sync_reset = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h99;
    @(negedge clk);
    sync_reset = 1'b0;
    bus.tx_valid = 1'b0;
    check("flush_txd", TXD, 1);
    check("flush_active", tx_active, 0);
    check("flush_count", fifo_count, 0);
    repeat (3) @(negedge clk);
    check("flush_still_idle", tx_active, 0);
    run_vec(vecs[0]);

    // Format change mid-frame applies only from the next frame
    @(negedge clk);
    set_cfg(2, 8, 0, 1'b0);
    start_cap();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hB7;
    @(negedge clk);
    bus.tx_data = 8'h5A;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    cfg_data_bits = 4'd6;
    add_frame(8'hB7, 8, 0, 1'b0, 3);
    add_frame(8'h5A, 6, 0, 1'b0, 3);
    wait_done();
    compare_wave("cfgchg");

    // Asynchronous reset during the start bit returns the line high without a clock
    @(negedge clk);
    set_cfg(3, 8, 0, 1'b0);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hA5;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_txd", TXD, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_txd", TXD, 1);
    check("arst_active", tx_active, 0);
    check("arst_ready", bus.tx_ready, 1);
    check("arst_count", fifo_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      int pm, nb, par, nw;
      bit s2;
      logic [7:0] d;
      pm = $urandom_range(1, 4);
      nb = $urandom_range(3, 10);
      par = $urandom_range(0, 3);
      s2 = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 4);
      @(negedge clk);
      set_cfg(pm, nb, par, s2);
      start_cap();
      for (int w = 0; w < nw; w++) begin
        d = 8'($urandom_range(0, 255));
        add_frame(d, nb, par, s2, pm + 1);
        bus.tx_valid = 1'b1;
        bus.tx_data = d;
        @(negedge clk);
      end
      bus.tx_valid = 1'b0;
      wait_done();
      compare_wave($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
